// File: rtl/wpt_ctrl_pkg.sv
// wpt_ctrl_pkg: shared definitions for the WPT RF front-end sequencer.
//   - 3-bit state codes (also driven on state_o for debug)
//   - rail register geometry: RAIL_W = 6 = {vcasc[1:0], vbias[3:0]}
package wpt_ctrl_pkg;

  localparam int RAIL_W  = 6;
  localparam int VBIAS_W = 4;
  localparam int VCASC_W = 2;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_RX        = 3'd2;
  localparam logic [2:0] ST_GUARD     = 3'd3;
  localparam logic [2:0] ST_TX        = 3'd4;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd5;

  typedef enum logic [2:0] {
    S_OFF       = ST_OFF,
    S_RAMP_UP   = ST_RAMP_UP,
    S_RX        = ST_RX,
    S_GUARD     = ST_GUARD,
    S_TX        = ST_TX,
    S_RAMP_DOWN = ST_RAMP_DOWN
  } state_t;

endpackage

// File: rtl/wpt_ctrl_if.sv
// wpt_ctrl_if: control/status bundle between the user-project logic and the
// WPT sequencer.
//   master (user logic): drives en_i, tx_req_i, settle_cyc_i, guard_cyc_i;
//                        observes rail, switch and status outputs.
//   slave  (wpt_ctrl)  : the reverse.
interface wpt_ctrl_if #(
  parameter int CNT_W = 8
);
  import wpt_ctrl_pkg::*;

  logic               en_i;
  logic               tx_req_i;
  logic [CNT_W-1:0]   settle_cyc_i;
  logic [CNT_W-1:0]   guard_cyc_i;
  logic [VBIAS_W-1:0] vbias_o;
  logic [VCASC_W-1:0] vcasc_o;
  logic               vswp_o;
  logic               ready_o;
  logic               tx_active_o;
  logic [2:0]         state_o;

  modport master (
    output en_i, tx_req_i, settle_cyc_i, guard_cyc_i,
    input  vbias_o, vcasc_o, vswp_o, ready_o, tx_active_o, state_o
  );

  modport slave (
    input  en_i, tx_req_i, settle_cyc_i, guard_cyc_i,
    output vbias_o, vcasc_o, vswp_o, ready_o, tx_active_o, state_o
  );

endinterface

// File: rtl/wpt_step_cnt.sv
// wpt_step_cnt: loadable down counter shared by the rail-step and guard
// intervals.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (0 remapped to 1) this edge
//   load_val  : interval length in cycles
//   expire    : high during the last cycle of a loaded interval, so the
//               owner acts on the edge that ends it; an interval of N
//               cycles expires N edges after the load edge.
module wpt_step_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // A zero-length interval would never expire; stretch it to one cycle.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= at_least_one(load_val);
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = (cnt == ONE);

endmodule

// File: rtl/wpt_ctrl.sv
// wpt_ctrl: power sequencer and TX/RX switch controller for the WPT RF
// front end.
//   wb_clk_i : system clock
//   wb_rst_i : synchronous active-high reset; rails drop at once
//   bus      : wpt_ctrl_if slave
//     en_i, tx_req_i, settle_cyc_i, guard_cyc_i  (in)
//     vbias_o[3:0], vcasc_o[1:0], vswp_o, ready_o, tx_active_o, state_o (out)
// Rails are a thermometer code {vcasc, vbias} brought up LSB first and taken
// down MSB first, one bit per settle interval. The switch moves through a
// break-before-make GUARD state whose length is guard_cyc_i.
module wpt_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  wpt_ctrl_if.slave  bus
);
  import wpt_ctrl_pkg::*;

  localparam logic [RAIL_W-1:0] RAIL_FIRST = {{(RAIL_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [RAIL_W-1:0] rail_q;
  logic              vswp_q;
  logic              ready_q;
  logic              tx_active_q;
  logic              target_tx;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_expire;

  logic              rail_full;
  logic              rail_last;

  assign rail_full = &rail_q;
  assign rail_last = (rail_q == RAIL_FIRST);

  // Counter loads mirror the FSM transitions below: settle interval on
  // every rail step (up or down), guard interval on each switch change.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = bus.settle_cyc_i;
    case (state)
      S_OFF:       cnt_load = bus.en_i;
      S_RAMP_UP:   cnt_load = !bus.en_i || (cnt_expire && !rail_full);
      S_RX: begin
        if (!bus.en_i) begin
          cnt_load = 1'b1;
        end else if (bus.tx_req_i) begin
          cnt_load = 1'b1;
          cnt_val  = bus.guard_cyc_i;
        end
      end
      S_TX: begin
        if (!bus.en_i) begin
          cnt_load = 1'b1;
        end else if (!bus.tx_req_i) begin
          cnt_load = 1'b1;
          cnt_val  = bus.guard_cyc_i;
        end
      end
      S_GUARD:     cnt_load = !bus.en_i;
      S_RAMP_DOWN: cnt_load = cnt_expire;
      default:     cnt_load = 1'b0;
    endcase
  end

  wpt_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (cnt_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_OFF;
      rail_q      <= '0;
      vswp_q      <= 1'b0;
      ready_q     <= 1'b0;
      tx_active_q <= 1'b0;
      target_tx   <= 1'b0;
    end else if (!bus.en_i && state != S_OFF && state != S_RAMP_DOWN) begin
      // Power-down wins from any active state, including mid-ramp and GUARD.
      // If only the first rail was up, it clears now and we are done.
      rail_q      <= rail_q >> 1;
      vswp_q      <= 1'b0;
      ready_q     <= 1'b0;
      tx_active_q <= 1'b0;
      state       <= rail_last ? S_OFF : S_RAMP_DOWN;
    end else begin
      case (state)
        S_OFF: begin
          if (bus.en_i) begin
            rail_q <= RAIL_FIRST;
            state  <= S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (cnt_expire) begin
            if (rail_full) begin
              state   <= S_RX;
              vswp_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              rail_q <= {rail_q[RAIL_W-2:0], 1'b1};
            end
          end
        end
        S_RX: begin
          if (bus.tx_req_i) begin
            target_tx <= 1'b1;
            vswp_q    <= 1'b0;
            ready_q   <= 1'b0;
            state     <= S_GUARD;
          end
        end
        S_TX: begin
          if (!bus.tx_req_i) begin
            target_tx   <= 1'b0;
            ready_q     <= 1'b0;
            tx_active_q <= 1'b0;
            state       <= S_GUARD;
          end
        end
        S_GUARD: begin
          // Target was latched on entry; tx_req_i is not looked at here.
          if (cnt_expire) begin
            ready_q <= 1'b1;
            if (target_tx) begin
              tx_active_q <= 1'b1;
              state       <= S_TX;
            end else begin
              vswp_q <= 1'b1;
              state  <= S_RX;
            end
          end
        end
        S_RAMP_DOWN: begin
          // en_i is ignored until OFF is reached.
          if (cnt_expire) begin
            rail_q <= rail_q >> 1;
            if (rail_last) state <= S_OFF;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign bus.vbias_o     = rail_q[VBIAS_W-1:0];
  assign bus.vcasc_o     = rail_q[RAIL_W-1:VBIAS_W];
  assign bus.vswp_o      = vswp_q;
  assign bus.ready_o     = ready_q;
  assign bus.tx_active_o = tx_active_q;
  assign bus.state_o     = state;

endmodule

// File: doc/wpt_ctrl.md
# wpt_ctrl

Sequencing controller for the WPT RF front end. Brings the four bias rails and two cascode rails up in a fixed order with programmable settle time, then drives the TX/RX switch (VSWP) with break-before-make guard intervals between the LNA (receive) and PA (transmit) paths. Powers down in reverse order. Sits between the Caravel user-project logic (Wishbone/logic-analyzer-driven control bits) and the WPT macro's VBias*/VCasc*/VSWP inputs.

## Interface
- CNT_W, 8, width of settle and guard cycle counts.
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  1 = power up and hold the front end; 0 = power down.
- tx_req_i  in  1  1 = request PA path; 0 = LNA path (level-sensitive).
- settle_cyc_i  in  CNT_W  cycles between rail steps; 0 is treated as 1 (S' = max(S,1)).
- guard_cyc_i  in  CNT_W  break-before-make interval; 0 is treated as 1 (G' = max(G,1)).
- vbias_o  out  4  to VBias1..VBias4 (bit 0 = VBias1).
- vcasc_o  out  2  to VCasc1, VCasc2.
- vswp_o  out  1  to VSWP; 1 = LNA path, 0 = PA path / isolated.
- ready_o  out  1  1 only in RX or TX steady state.
- tx_active_o  out  1  1 only in TX.
- state_o  out  3  current state encoding (debug).

## Operation
- Rails held in one 6-bit thermometer register rail_q = {vcasc_o, vbias_o}; only one bit changes per step.
- States: OFF, RAMP_UP, RX, GUARD, TX, RAMP_DOWN.
- OFF: all outputs 0. en_i=1 -> RAMP_UP; rail_q bit 0 set on the transition; step counter loaded with S'.
- RAMP_UP: each time counter expires, set lowest clear rail_q bit and reload S'. When rail_q becomes all-ones, the next expiry enters RX.
- RX: vswp_o=1, ready_o=1. tx_req_i=1 -> GUARD with target TX.
- TX: vswp_o=0, ready_o=1, tx_active_o=1. tx_req_i=0 -> GUARD with target RX.
- GUARD: vswp_o=0, ready_o=0, tx_active_o=0; counter loaded with G' on entry; target latched on entry; changes to tx_req_i during GUARD are ignored; on expiry enter the target, where tx_req_i is re-evaluated on the next cycle.
- en_i=0 in any non-OFF state (including mid-ramp and GUARD) -> RAMP_DOWN: vswp_o, ready_o, tx_active_o forced 0; highest set rail_q bit cleared on entry; then one further bit cleared per S' cycles. Enter OFF in the same cycle the last bit clears.
- en_i reasserted during RAMP_DOWN is ignored until OFF is reached; OFF then restarts RAMP_UP on the next cycle.
- settle_cyc_i/guard_cyc_i are sampled only at counter load; changes mid-interval take effect at the next load.
- Reset (wb_rst_i=1 at an edge, any state): next cycle state OFF, rail_q=0, all outputs 0, counter 0. Rails drop immediately; no ordered ramp on reset.

## Timing
- All outputs registered; no combinational input-to-output path.
- Power-up, en_i sampled 1 at edge k in OFF: vbias_o[i] rises at k+1+i·S' (i=0..3); vcasc_o[j] at k+1+(4+j)·S'; RX (vswp_o=1, ready_o=1) at k+1+6·S'.
- RX->TX, tx_req_i sampled 1 at edge m: vswp_o=0, ready_o=0 at m+1; TX (tx_active_o=1, ready_o=1) at m+1+G'.
- TX->RX, tx_req_i sampled 0 at edge m: tx_active_o=0, ready_o=0 at m+1; vswp_o=1, ready_o=1 at m+1+G'.
- Power-down from full rails, en_i sampled 0 at edge m: vswp_o=0 and vcasc_o[1]=0 at m+1; subsequent bits clear at m+1+n·S' (n=1..5); OFF at m+1+5·S'.
- vswp_o is never 1 while rail_q is not all-ones.

## Structure
- Shared package wpt_ctrl_pkg: state encodings (3-bit localparams), RAIL_W=6, debug state_o codes.
- One sub-module, wpt_step_cnt: loadable CNT_W down counter with zero-remap to 1 and an expire pulse; instantiated once and shared by ramp and guard intervals.

## Test plan
- Reset, S=3: en_i=1 at edge 0 -> vbias_o=0001@1, 0011@4, 0111@7, 1111@10; vcasc_o=01@13, 11@16; vswp_o=1, ready_o=1@19.
- From RX, G=2: tx_req_i=1 at edge 30 -> vswp_o=0@31, tx_active_o=1@33; tx_req_i=0 at edge 40 -> tx_active_o=0@41, vswp_o=1@43.
- S=0, G=0: full ramp completes in 6 cycles; each guard lasts 1 cycle; no 0-cycle steps.
- en_i=0 at edge 8 mid-ramp with S=3 (vbias_o=0111) -> vbias_o=0011@9, 0001@12, 0000 and OFF@15; en_i pulsed high at edge 10 is ignored.
- tx_req_i toggled 1->0 during GUARD toward TX -> TX still entered after G', then GUARD back to RX starts one cycle later.
- wb_rst_i=1 in TX -> all outputs 0 and state_o=OFF the next cycle.
